// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters gating instruction issue on RAW hazards and WAW counter saturation.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int AW        = $clog2(NUM_REGS),
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           iss_valid,
  input  logic                           iss_dst_en,
  input  logic [AW-1:0]                  iss_dst,
  input  logic [NUM_SRC-1:0]             iss_src_en,
  input  logic [NUM_SRC-1:0][AW-1:0]     iss_src,
  output logic                           iss_ready,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB-1:0][AW-1:0]      wb_dst,
  input  logic                           flush,
  output logic                           busy,
  output logic                           err_underflow,
  output logic [15:0]                    stall_cycles
);
  localparam int SW = CNT_W + $clog2(NUM_WB + 1) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_nxt;
  logic [NUM_REGS-1:0][SW-1:0]    w_dec;
  logic [NUM_REGS-1:0]            w_wbz;
  logic [SW-1:0]                  w_sum;
  logic                           w_haz, w_waw, w_fire, w_uf;
  logic                           r_err;
  logic [15:0]                    r_stall;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < NUM_WB; p++)
        w_dec[r] = w_dec[r] + SW'(wb_valid[p] && wb_dst[p] == AW'(r));
      w_wbz[r] = w_dec[r] >= SW'(r_cnt[r]);
    end
  end
  // The bypass looks only at writebacks, so readiness never depends on this cycle's issue.
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (iss_src_en[i] && iss_src[i] != '0 && r_cnt[iss_src[i]] != '0 &&
          !((WB_BYPASS != 0) && w_wbz[iss_src[i]]))
        w_haz = 1'b1;
    w_waw = iss_dst_en && iss_dst != '0 && r_cnt[iss_dst] == CMAX && w_dec[iss_dst] == '0;
    iss_ready = !flush && !w_haz && !w_waw;
  end
  always_comb begin
    w_fire = iss_valid && iss_ready;
    w_uf = 1'b0;
    w_sum = '0;
    w_nxt[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_sum = SW'(r_cnt[r]) + SW'(w_fire && iss_dst_en && iss_dst == AW'(r));
      w_nxt[r] = w_dec[r] > w_sum ? '0 : CNT_W'(w_sum - w_dec[r]);
      w_uf = w_uf || w_dec[r] > w_sum;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      r_stall <= '0;
    end else begin
      r_cnt <= flush ? '0 : w_nxt;
      if (!flush && w_uf) r_err <= 1'b1;
      if (iss_valid && !iss_ready && ~&r_stall) r_stall <= r_stall + 16'd1;
    end
  end
  assign busy = |r_cnt;
  assign err_underflow = r_err;
  assign stall_cycles = r_stall;
endmodule
